fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: BOOT/FETCH/EXEC instruction sequencer with PC update.
// Optional stall counter enabled by FETCH_SEQ_STALL_CNT_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR_READDATA,
    input  logic        INSTR_BUSYWAIT,
    input  logic        JUMP,
    input  logic        BRANCH,
    input  logic        ZERO,
    input  logic        DATA_BUSYWAIT,
    output logic        INSTR_READ,
    output logic [31:0] PC,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID,
    output logic [15:0] STALL_COUNT
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        flow;
    logic [31:0] br_off;
    logic [31:0] pc_seq;

    assign flow   = JUMP ^ (BRANCH & ZERO);
    assign br_off = {{22{instr_q[23]}}, instr_q[23:16], 2'b00};
    assign pc_seq = pc_q + 32'd4;

    // State, PC and instruction registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state, PC/instruction update and handshake outputs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        INSTR_READ  = 1'b0;
        INSTR_VALID = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                INSTR_READ = 1'b1;
                if (!INSTR_BUSYWAIT) begin
                    instr_d = INSTR_READDATA;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                INSTR_VALID = 1'b1;
                if (!DATA_BUSYWAIT) begin
                    pc_d    = flow ? (pc_seq + br_off) : pc_seq;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign PC          = pc_q;
    assign INSTRUCTION = instr_q;

`ifdef FETCH_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic        stalled;

    assign stalled = ((state_q == FETCH) && INSTR_BUSYWAIT) ||
                     ((state_q == EXEC) && DATA_BUSYWAIT);

    // Saturating count of memory wait cycles
    always_comb begin
        stall_d = stall_q;
        if (stalled && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign STALL_COUNT = stall_q;
`else
    assign STALL_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors for fetch_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_sequencer;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTR_READDATA;
    logic        INSTR_BUSYWAIT;
    logic        JUMP;
    logic        BRANCH;
    logic        ZERO;
    logic        DATA_BUSYWAIT;
    logic        INSTR_READ;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic [15:0] STALL_COUNT;

    int n_cmp;
    int n_bad;

    fetch_sequencer #(.RESET_PC(32'd0)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .INSTR_READDATA (INSTR_READDATA),
        .INSTR_BUSYWAIT (INSTR_BUSYWAIT),
        .JUMP           (JUMP),
        .BRANCH         (BRANCH),
        .ZERO           (ZERO),
        .DATA_BUSYWAIT  (DATA_BUSYWAIT),
        .INSTR_READ     (INSTR_READ),
        .PC             (PC),
        .INSTRUCTION    (INSTRUCTION),
        .INSTR_VALID    (INSTR_VALID),
        .STALL_COUNT    (STALL_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] off);
        return {8'h5A, off, 16'h1234};
    endfunction

    // Entered at a falling edge with the DUT in FETCH; leaves it at the
    // falling edge after the PC update (back in FETCH).
    task automatic run(input logic [31:0] word, input logic j,
                       input logic b, input logic z, input int iw,
                       input int dw, input logic [31:0] exp_pc);
        logic [31:0] pc0;
        logic [31:0] ins0;
        pc0  = PC;
        ins0 = INSTRUCTION;
        check("fetch_read", {31'd0, INSTR_READ}, 32'd1);
        check("fetch_valid", {31'd0, INSTR_VALID}, 32'd0);
        JUMP   = 1'b1;
        BRANCH = 1'b1;
        ZERO   = 1'b0;
        for (int i = 0; i < iw; i++) begin
            INSTR_READDATA = 32'hDEADBEEF;
            INSTR_BUSYWAIT = 1'b1;
            @(negedge CLK);
            check("iwait_pc", PC, pc0);
            check("iwait_ins", INSTRUCTION, ins0);
            check("iwait_read", {31'd0, INSTR_READ}, 32'd1);
        end
        INSTR_READDATA = word;
        INSTR_BUSYWAIT = 1'b0;
        @(negedge CLK);
        INSTR_READDATA = 32'hCAFEF00D;
        INSTR_BUSYWAIT = 1'b1;
        check("exec_valid", {31'd0, INSTR_VALID}, 32'd1);
        check("exec_read", {31'd0, INSTR_READ}, 32'd0);
        check("exec_ins", INSTRUCTION, word);
        check("exec_pc", PC, pc0);
        JUMP   = j;
        BRANCH = b;
        ZERO   = z;
        for (int i = 0; i < dw; i++) begin
            DATA_BUSYWAIT = 1'b1;
            @(negedge CLK);
            check("dwait_pc", PC, pc0);
            check("dwait_ins", INSTRUCTION, word);
            check("dwait_valid", {31'd0, INSTR_VALID}, 32'd1);
        end
        DATA_BUSYWAIT = 1'b0;
        @(negedge CLK);
        INSTR_BUSYWAIT = 1'b0;
        check("next_pc", PC, exp_pc);
        check("next_valid", {31'd0, INSTR_VALID}, 32'd0);
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        CLK            = 1'b0;
        RESET          = 1'b0;
        INSTR_READDATA = 32'd0;
        INSTR_BUSYWAIT = 1'b0;
        JUMP           = 1'b0;
        BRANCH         = 1'b0;
        ZERO           = 1'b0;
        DATA_BUSYWAIT  = 1'b0;

        #2 RESET = 1'b1;
        #1;
        check("rst_pc", PC, 32'd0);
        check("rst_ins", INSTRUCTION, 32'd0);
        check("rst_read", {31'd0, INSTR_READ}, 32'd0);
        check("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
        check("rst_stall", {16'd0, STALL_COUNT}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("boot_read", {31'd0, INSTR_READ}, 32'd0);
        check("boot_valid", {31'd0, INSTR_VALID}, 32'd0);
        @(negedge CLK);
        check("boot_pc", PC, 32'd0);

        run(mk(8'h7F), 1'b0, 1'b0, 1'b1, 0, 0, 32'h04);
        run(mk(8'h7F), 1'b0, 1'b1, 1'b0, 0, 0, 32'h08);
        run(mk(8'h01), 1'b0, 1'b0, 1'b0, 0, 0, 32'h0C);
        run(mk(8'h00), 1'b0, 1'b0, 1'b0, 0, 0, 32'h10);
        run(mk(8'hFE), 1'b1, 1'b0, 1'b0, 0, 0, 32'h0C);
        run(mk(8'h04), 1'b1, 1'b0, 1'b1, 0, 0, 32'h20);
        run(mk(8'h03), 1'b0, 1'b1, 1'b1, 0, 0, 32'h30);
        run(mk(8'hFB), 1'b1, 1'b0, 1'b0, 0, 0, 32'h20);
        run(mk(8'h03), 1'b0, 1'b1, 1'b0, 0, 0, 32'h24);
        run(mk(8'h06), 1'b1, 1'b0, 1'b0, 0, 0, 32'h40);
        run(mk(8'h02), 1'b1, 1'b1, 1'b0, 0, 0, 32'h4C);
        run(mk(8'hFC), 1'b1, 1'b0, 1'b0, 0, 0, 32'h40);
        run(mk(8'h02), 1'b1, 1'b1, 1'b1, 0, 0, 32'h44);
        check("stall_pre", {16'd0, STALL_COUNT}, 32'd0);
        run(mk(8'h10), 1'b0, 1'b0, 1'b0, 5, 3, 32'h48);
`ifdef FETCH_SEQ_STALL_CNT_EN
        check("stall_cnt", {16'd0, STALL_COUNT}, 32'd8);
`else
        check("stall_cnt", {16'd0, STALL_COUNT}, 32'd0);
`endif

        INSTR_READDATA = mk(8'h20);
        INSTR_BUSYWAIT = 1'b0;
        JUMP           = 1'b1;
        BRANCH         = 1'b0;
        ZERO           = 1'b0;
        @(negedge CLK);
        INSTR_BUSYWAIT = 1'b1;
        DATA_BUSYWAIT  = 1'b1;
        @(negedge CLK);
        check("mid_valid", {31'd0, INSTR_VALID}, 32'd1);
        check("mid_pc", PC, 32'h48);
        #2 RESET = 1'b1;
        #1;
        check("arst_pc", PC, 32'd0);
        check("arst_ins", INSTRUCTION, 32'd0);
        check("arst_read", {31'd0, INSTR_READ}, 32'd0);
        check("arst_valid", {31'd0, INSTR_VALID}, 32'd0);
        check("arst_stall", {16'd0, STALL_COUNT}, 32'd0);
        @(negedge CLK);
        RESET          = 1'b0;
        DATA_BUSYWAIT  = 1'b0;
        INSTR_BUSYWAIT = 1'b0;
        #1;
        check("reboot_read", {31'd0, INSTR_READ}, 32'd0);
        check("reboot_pc", PC, 32'd0);
        @(negedge CLK);
        check("refetch_read", {31'd0, INSTR_READ}, 32'd1);

        run(mk(8'hFE), 1'b1, 1'b0, 1'b0, 0, 0, 32'hFFFFFFFC);
        run(mk(8'h55), 1'b0, 1'b0, 1'b0, 0, 0, 32'h00000000);
        run(mk(8'h80), 1'b0, 1'b1, 1'b1, 0, 0, 32'hFFFFFE04);
        run(mk(8'h7F), 1'b1, 1'b0, 1'b0, 0, 0, 32'h00000004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
